led_pulse_stretcher: RTL and testbench

//   Output-side counterpart of the button input path: turns short internal events
//   (1-cycle strobes or levels) into human-visible LED blinks of fixed length.

---
 rtl/led_pulse_stretcher_pkg.sv | 16 +
 rtl/led_pulse_stretcher_edge_detect.sv | 24 ++
 rtl/led_pulse_stretcher.sv | 111 +++++++++++
 tb/tb_led_pulse_stretcher.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pulse_stretcher_pkg.sv
// Shared definitions for the board LED/buzzer output drivers.
package led_pulse_stretcher_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } led_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_edge_detect.sv
// Rising-edge strobe generator; the previous-value flop resets to RST_VAL so a
// level already high at reset release does not register as an edge.
module edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic sig_q;
  logic sig_d;

  always_comb sig_d = sig_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= RST_VAL;
    else     sig_q <= sig_d;
  end

  assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches event strobes into fixed-length LED blinks separated by a dark gap;
// events arriving while busy are queued in a saturating counter and replayed.
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 10_000_000,
  parameter int unsigned GAP_CYCLES = 5_000_000,
  parameter int unsigned PEND_W     = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              event_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending_count,
  output logic              overflow
);

  localparam int unsigned CNT_W = $clog2(max_u(ON_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  led_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              rise;
  logic              start;

  edge_detect #(
    .RST_VAL (1'b1)
  ) u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (event_in),
    .rise   (rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;
    start   = 1'b0;

    unique case (state_q)
      ST_IDLE: start = rise || (pend_q != '0);
      ST_ON: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          if (rise || (pend_q != '0)) start = 1'b1;
          else                        state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d = ST_ON;
      cnt_d   = ON_LOAD;
    end

    // A start consumes one queued event if any, else the same-cycle edge;
    // an edge alongside a consumed queued event simply takes its slot.
    if (start) begin
      if ((pend_q != '0) && !rise) pend_d = pend_q - PEND_W'(1);
    end else if (rise) begin
      if (pend_q == '1) ovf_d  = 1'b1;
      else              pend_d = pend_q + PEND_W'(1);
    end

    led_d  = (state_d == ST_ON) ^ ACTIVE_LOW;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      led_q   <= ACTIVE_LOW;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign led_out       = led_q;
  assign busy          = busy_q;
  assign pending_count = pend_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Scoreboard bench: a timeline model predicts blink start cycles and per-cycle
// outputs; a negedge monitor compares the DUT against those predictions.
module tb_led_pulse_stretcher;

  localparam int ON   = 4;
  localparam int GAP  = 2;
  localparam int PW   = 2;
  localparam bit AL   = 1'b0;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          event_in = 1'b0;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending_count;
  logic          overflow;

  led_pulse_stretcher #(
    .ON_CYCLES  (ON),
    .GAP_CYCLES (GAP),
    .PEND_W     (PW),
    .ACTIVE_LOW (AL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .event_in      (event_in),
    .led_out       (led_out),
    .busy          (busy),
    .pending_count (pending_count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];

  // Model state: times are absolute cycle numbers
  bit m_led  = 1'b0;
  bit m_busy = 1'b0;
  bit m_ovf  = 1'b0;
  bit m_prev = 1'b1;
  int m_pend = 0;
  int free_at = 0;
  int cur_s   = -1000;

  int blinks = 0, ovf_seen = 0, last_start = -1, prev_start = -1;
  bit lit_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: a blink may start once the previous blink plus gap has elapsed
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_prev  = 1'b1;
      m_pend  = 0;
      free_at = 0;
      cur_s   = -1000;
      m_ovf   = 1'b0;
      exp_q.delete();
    end else begin
      bit e;
      e      = event_in & ~m_prev;
      m_prev = event_in;
      m_ovf  = 1'b0;
      if ((e || m_pend > 0) && cyc >= free_at) begin
        if (m_pend > 0 && !e) m_pend--;
        cur_s   = cyc;
        free_at = cyc + ON + GAP;
        exp_q.push_back(cyc);
      end else if (e) begin
        if (m_pend == PMAX) m_ovf = 1'b1;
        else                m_pend++;
      end
    end
    m_led  = (cyc >= cur_s) && (cyc < cur_s + ON);
    m_busy = (cyc < free_at);
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("rst_led", led_out, AL);
      check("rst_busy", busy, 0);
      check("rst_pending", pending_count, 0);
      check("rst_overflow", overflow, 0);
      lit_prev = 1'b0;
    end else begin
      bit lit;
      check("led", led_out, m_led ^ AL);
      check("busy", busy, m_busy);
      check("pending", pending_count, m_pend);
      check("overflow", overflow, m_ovf);
      if (overflow) ovf_seen++;
      lit = led_out ^ AL;
      if (lit && !lit_prev) begin
        blinks++;
        prev_start = last_start;
        last_start = cyc;
        check("blink_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("blink_start", cyc, exp_q.pop_front());
      end
      lit_prev = lit;
    end
  end

  task automatic strobes(input int n);
    repeat (n) begin
      event_in = 1'b1; step(1);
      event_in = 1'b0; step(1);
    end
  endtask

  initial begin
    int b0, o0;
    rst = 1'b1; event_in = 1'b0;
    step(3);
    rst = 1'b0;
    step(5);

    // single strobe
    b0 = blinks;
    event_in = 1'b1; step(1); event_in = 1'b0;
    step(20);
    check("s1_blinks", blinks - b0, 1);
    check("s1_busy_after", busy, 0);

    // three strobes, queued and replayed back to back
    b0 = blinks;
    strobes(3);
    step(30);
    check("s2_blinks", blinks - b0, 3);
    check("s2_spacing", last_start - prev_start, ON + GAP);
    check("s2_pending", pending_count, 0);

    // six strobes: queue saturates, one edge dropped
    b0 = blinks; o0 = ovf_seen;
    strobes(6);
    step(50);
    check("s3_blinks", blinks - b0, 5);
    check("s3_overflows", ovf_seen - o0, 1);

    // long level: a single edge
    b0 = blinks;
    event_in = 1'b1; step(20); event_in = 1'b0;
    step(20);
    check("s4_blinks", blinks - b0, 1);

    // level held high across reset release
    b0 = blinks;
    event_in = 1'b1; rst = 1'b1; step(2);
    rst = 1'b0; step(10);
    event_in = 1'b0; step(20);
    check("s5_blinks", blinks - b0, 0);

    // reset while busy with events queued
    b0 = blinks;
    strobes(2);
    event_in = 1'b1; step(1); event_in = 1'b0;
    check("s6_pending_before", pending_count, 2);
    rst = 1'b1; #1;
    check("s6_led_dark", led_out, AL);
    check("s6_pending_cleared", pending_count, 0);
    step(1); rst = 1'b0;
    step(30);
    check("s6_blinks", blinks - b0, 1);

    // strobe in the final gap cycle starts the next blink without an idle cycle
    b0 = blinks;
    event_in = 1'b1; step(1); event_in = 1'b0;
    step(ON + GAP - 1);
    event_in = 1'b1; step(1); event_in = 1'b0;
    step(20);
    check("s7_blinks", blinks - b0, 2);
    check("s7_back_to_back", last_start - prev_start, ON + GAP);

    // random traffic with occasional resets
    repeat (3000) begin
      event_in = ($urandom_range(0, 2) == 0);
      rst      = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 1'b0; event_in = 1'b0;
    step(40);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
